block_mem_responder: RTL

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

---
 rtl/block_mem_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/block_mem_responder.sv
// Block-wide memory responder: samples one request, answers LATENCY cycles later
// with a single ack pulse, then enforces one idle GAP cycle before the next request.
module block_mem_responder #(
  parameter int ADDR_WIDTH   = 30,
  parameter int WORD_WIDTH   = 32,
  parameter int BLOCK_SIZE   = 4,
  parameter int DEPTH_BLOCKS = 256,
  parameter int LATENCY      = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_WIDTH-1:0]                mrq_addr,
  input  logic                                 mrq_cs,
  input  logic                                 mrq_rw,
  input  logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] mrq_data,
  output logic                                 mrs_ack,
  output logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] mrs_data,
  output logic                                 busy,
  output logic [15:0]                          rd_count,
  output logic [15:0]                          wr_count
);

  localparam int OFF_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 0;
  localparam int IDX_W = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, GAP} state_t;

  state_t                                 state;
  logic [7:0]                             cnt;
  logic [IDX_W-1:0]                       lat_idx;
  logic                                   lat_rw;
  logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0]  lat_data;
  logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0]  mem [DEPTH_BLOCKS];
  logic                                   complete;
  logic                                   addr_unused;

  // Offset and upper address bits only alias; they never select storage.
  assign addr_unused = ^mrq_addr;
  assign complete    = (state == BUSY) && (cnt == 8'd0);
  assign busy        = (state != IDLE);

  // GAP behaves like IDLE at its closing edge so a held request re-issues
  // exactly LATENCY+2 cycles after the previous sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mrs_ack  <= 1'b0;
      mrs_data <= '0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
      cnt      <= 8'd0;
      lat_idx  <= '0;
      lat_rw   <= 1'b0;
      lat_data <= '0;
    end else begin
      mrs_ack <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (mrq_cs) begin
            lat_idx  <= mrq_addr[OFF_W +: IDX_W];
            lat_rw   <= mrq_rw;
            lat_data <= mrq_data;
            cnt      <= 8'(LATENCY - 1);
            state    <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            state   <= ACK;
            mrs_ack <= 1'b1;
            if (lat_rw) begin
              wr_count <= wr_count + 16'd1;
            end else begin
              rd_count <= rd_count + 16'd1;
              mrs_data <= mem[lat_idx];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK:     state <= GAP;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain; the rst gate drops a
  // write whose completion edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && complete && lat_rw) begin
      mem[lat_idx] <= lat_data;
    end
  end

endmodule
